// File: rtl/cc_geo_engine_if.sv
// Point-stream / result handshake bundle for cc_geo_engine.
// The producer/consumer side takes the master modport, the engine takes slave.
interface cc_geo_engine_if #(
  parameter int unsigned CW   = 8,
  parameter int unsigned MAXV = 8
) ();
  localparam int unsigned NVW = $clog2(MAXV) + 1;
  localparam int unsigned AW  = 2 * CW + $clog2(MAXV);

  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            mode;
  logic [NVW-1:0]        nv;
  logic signed [CW-1:0]  xi;
  logic signed [CW-1:0]  yi;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [AW-1:0]  out_x;
  logic signed [AW-1:0]  out_y;
  logic                  err;

  modport master (
    output in_valid, mode, nv, xi, yi, out_ready,
    input  in_ready, out_valid, out_x, out_y, err
  );

  modport slave (
    input  in_valid, mode, nv, xi, yi, out_ready,
    output in_ready, out_valid, out_x, out_y, err
  );
endinterface

// File: rtl/cc_geo_engine.sv
// Streaming geometry engine: shoelace area, line/circle relation or bounding box
// over a burst of signed points, with a two-stage finish before the result handshake.
module cc_geo_engine #(
  parameter int unsigned CW   = 8,
  parameter int unsigned MAXV = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  cc_geo_engine_if.slave  io_bus
);
  localparam int unsigned NVW = $clog2(MAXV) + 1;
  localparam int unsigned AW  = 2 * CW + $clog2(MAXV);
  localparam int unsigned SW  = AW + 1;
  localparam int unsigned LW  = 4 * CW + 8;

  typedef enum logic [2:0] {
    StIdle, StCollect, StDrain, StErr, StCalc, StRes, StOut1, StOut2
  } state_e;

  state_e r_state, w_state_d;

  logic [1:0]           r_mode;
  logic [NVW-1:0]       r_nv, r_cnt;
  logic signed [CW-1:0] r_x0, r_y0, r_xp, r_yp;
  logic signed [CW-1:0] r_p1x, r_p1y, r_p2x, r_p2y;
  logic signed [CW-1:0] r_minx, r_miny, r_maxx, r_maxy;
  logic signed [SW-1:0] r_acc;
  logic signed [LW-1:0] r_l, r_r;
  logic signed [AW-1:0] r_out_x, r_out_y;

  logic                 w_xfer, w_nv_legal;
  logic [NVW-1:0]       w_cnt_inc, w_n;
  logic signed [SW-1:0] w_term, w_wrap, w_abs;
  logic signed [LW-1:0] w_a, w_b, w_c, w_s, w_dx, w_dy, w_l, w_r;

  function automatic logic signed [SW-1:0] sx_s(input logic signed [CW-1:0] v);
    return {{(SW-CW){v[CW-1]}}, v};
  endfunction

  function automatic logic signed [LW-1:0] sx_l(input logic signed [CW-1:0] v);
    return {{(LW-CW){v[CW-1]}}, v};
  endfunction

  function automatic logic signed [AW-1:0] sx_a(input logic signed [CW-1:0] v);
    return {{(AW-CW){v[CW-1]}}, v};
  endfunction

  assign w_xfer     = io_bus.in_valid && io_bus.in_ready;
  assign w_cnt_inc  = r_cnt + NVW'(1);
  assign w_n        = (r_mode == 2'd1) ? NVW'(4) : r_nv;
  assign w_nv_legal = (io_bus.nv >= NVW'(3)) && (io_bus.nv <= NVW'(MAXV));

  // Shoelace cross terms: running edge (prev -> incoming) and closing edge (last -> first).
  assign w_term = sx_s(r_xp) * sx_s(io_bus.yi) - sx_s(io_bus.xi) * sx_s(r_yp);
  assign w_wrap = sx_s(r_xp) * sx_s(r_y0) - sx_s(r_x0) * sx_s(r_yp);
  assign w_abs  = r_acc[SW-1] ? -r_acc : r_acc;

  // Line p0-p1 against circle centred p2 through p3 (p3 is the last beat).
  // LW leaves headroom so every product is exact.
  assign w_a  = sx_l(r_y0) - sx_l(r_p1y);
  assign w_b  = sx_l(r_p1x) - sx_l(r_x0);
  assign w_c  = sx_l(r_x0) * sx_l(r_p1y) - sx_l(r_p1x) * sx_l(r_y0);
  assign w_s  = w_a * sx_l(r_p2x) + w_b * sx_l(r_p2y) + w_c;
  assign w_dx = sx_l(r_p2x) - sx_l(r_xp);
  assign w_dy = sx_l(r_p2y) - sx_l(r_yp);
  assign w_l  = w_s * w_s;
  assign w_r  = (w_a * w_a + w_b * w_b) * (w_dx * w_dx + w_dy * w_dy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_xfer) begin
          if (io_bus.mode == 2'd3 || (io_bus.mode != 2'd1 && !w_nv_legal)) begin
            w_state_d = StDrain;
          end else begin
            w_state_d = StCollect;
          end
        end
      end
      StCollect: begin
        if (!io_bus.in_valid)    w_state_d = StErr;
        else if (w_cnt_inc == w_n) w_state_d = StCalc;
      end
      StDrain:  if (!io_bus.in_valid) w_state_d = StErr;
      StErr:    w_state_d = StIdle;
      StCalc:   w_state_d = StRes;
      StRes:    w_state_d = StOut1;
      StOut1: begin
        if (io_bus.out_ready) w_state_d = (r_mode == 2'd2) ? StOut2 : StIdle;
      end
      StOut2:   if (io_bus.out_ready) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    io_bus.in_ready  = (r_state == StIdle) || (r_state == StCollect) || (r_state == StDrain);
    io_bus.out_valid = (r_state == StOut1) || (r_state == StOut2);
    io_bus.err       = (r_state == StErr);
    io_bus.out_x     = r_out_x;
    io_bus.out_y     = r_out_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= '0;
      r_nv    <= '0;
      r_cnt   <= '0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_xp    <= '0;
      r_yp    <= '0;
      r_p1x   <= '0;
      r_p1y   <= '0;
      r_p2x   <= '0;
      r_p2y   <= '0;
      r_minx  <= '0;
      r_miny  <= '0;
      r_maxx  <= '0;
      r_maxy  <= '0;
      r_acc   <= '0;
      r_l     <= '0;
      r_r     <= '0;
      r_out_x <= '0;
      r_out_y <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_xfer) begin
            r_mode <= io_bus.mode;
            r_nv   <= io_bus.nv;
            r_cnt  <= NVW'(1);
            r_x0   <= io_bus.xi;
            r_y0   <= io_bus.yi;
            r_xp   <= io_bus.xi;
            r_yp   <= io_bus.yi;
            r_minx <= io_bus.xi;
            r_miny <= io_bus.yi;
            r_maxx <= io_bus.xi;
            r_maxy <= io_bus.yi;
            r_acc  <= '0;
          end
        end
        StCollect: begin
          if (w_xfer) begin
            r_cnt <= w_cnt_inc;
            r_xp  <= io_bus.xi;
            r_yp  <= io_bus.yi;
            r_acc <= r_acc + w_term;
            if (r_cnt == NVW'(1)) begin
              r_p1x <= io_bus.xi;
              r_p1y <= io_bus.yi;
            end
            if (r_cnt == NVW'(2)) begin
              r_p2x <= io_bus.xi;
              r_p2y <= io_bus.yi;
            end
            if (io_bus.xi < r_minx) r_minx <= io_bus.xi;
            if (io_bus.yi < r_miny) r_miny <= io_bus.yi;
            if (io_bus.xi > r_maxx) r_maxx <= io_bus.xi;
            if (io_bus.yi > r_maxy) r_maxy <= io_bus.yi;
          end
        end
        StCalc: begin
          r_acc <= r_acc + w_wrap;
          r_l   <= w_l;
          r_r   <= w_r;
        end
        StRes: begin
          case (r_mode)
            2'd1: begin
              r_out_x <= '0;
              if (r_l > r_r)      r_out_y <= '0;
              else if (r_l < r_r) r_out_y <= AW'(1);
              else                r_out_y <= AW'(2);
            end
            2'd2: begin
              r_out_x <= sx_a(r_minx);
              r_out_y <= sx_a(r_miny);
            end
            default: begin
              r_out_x <= '0;
              r_out_y <= AW'(w_abs >> 1);
            end
          endcase
        end
        StOut1: begin
          if (io_bus.out_ready && r_mode == 2'd2) begin
            r_out_x <= sx_a(r_maxx);
            r_out_y <= sx_a(r_maxy);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cc_geo_engine.sv
// Directed bench for cc_geo_engine: area, line/circle, bounding box, error paths and reset.
module tb_cc_geo_engine;
  localparam int unsigned CW   = 8;
  localparam int unsigned MAXV = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   px[8];
  int   py[8];

  cc_geo_engine_if #(.CW(CW), .MAXV(MAXV)) io ();

  cc_geo_engine #(.CW(CW), .MAXV(MAXV)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive n beats back to back from px/py, then drop in_valid.
  task automatic burst(input int m, input int nvv, input int n);
    for (int i = 0; i < n; i++) begin
      io.in_valid = 1'b1;
      io.mode     = 2'(m);
      io.nv       = 4'(nvv);
      io.xi       = 8'(px[i]);
      io.yi       = 8'(py[i]);
      step();
    end
    io.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!io.out_valid && k < 10) begin
      step();
      k++;
    end
    chk({tag, "_valid"}, int'(io.out_valid), 1);
  endtask

  task automatic accept();
    io.out_ready = 1'b1;
    step();
    io.out_ready = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int ex, input int ey);
    wait_valid(tag);
    chk({tag, "_x"}, int'(io.out_x), ex);
    chk({tag, "_y"}, int'(io.out_y), ey);
    accept();
    chk({tag, "_done"}, int'(io.out_valid), 0);
  endtask

  task automatic expect_err(input string tag);
    int k   = 0;
    int saw = 0;
    while (!io.err && k < 8) begin
      if (io.out_valid) saw = 1;
      step();
      k++;
    end
    chk({tag, "_err"}, int'(io.err), 1);
    chk({tag, "_noout"}, saw | int'(io.out_valid), 0);
    step();
    chk({tag, "_errpulse"}, int'(io.err), 0);
    chk({tag, "_idle"}, int'(io.in_ready), 1);
  endtask

  task automatic load_square();
    px[0] = 0; py[0] = 0;
    px[1] = 4; py[1] = 0;
    px[2] = 4; py[2] = 4;
    px[3] = 0; py[3] = 4;
  endtask

  task automatic load_tri();
    px[0] = 0; py[0] = 0;
    px[1] = 3; py[1] = 0;
    px[2] = 0; py[2] = 3;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    io.in_valid  = 1'b0;
    io.mode      = '0;
    io.nv        = '0;
    io.xi        = '0;
    io.yi        = '0;
    io.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      px[i] = 0;
      py[i] = 0;
    end

    #12;
    chk("rst_out_valid", int'(io.out_valid), 0);
    chk("rst_out_x", int'(io.out_x), 0);
    chk("rst_out_y", int'(io.out_y), 0);
    chk("rst_err", int'(io.err), 0);
    chk("rst_in_ready", int'(io.in_ready), 1);
    rst_n = 1'b1;
    step();

    // Square with exact latency: last beat at T, out_valid at T+2.
    load_square();
    burst(0, 4, 4);
    chk("sq_t0_ready", int'(io.in_ready), 0);
    chk("sq_t0_valid", int'(io.out_valid), 0);
    step();
    chk("sq_t1_ready", int'(io.in_ready), 0);
    chk("sq_t1_valid", int'(io.out_valid), 0);
    step();
    chk("sq_t2_valid", int'(io.out_valid), 1);
    chk("sq_t2_ready", int'(io.in_ready), 0);
    chk("sq_x", int'(io.out_x), 0);
    chk("sq_y", int'(io.out_y), 16);
    accept();
    chk("sq_done", int'(io.out_valid), 0);
    chk("sq_back_idle", int'(io.in_ready), 1);

    // Triangles, both windings.
    load_tri();
    burst(0, 3, 3);
    expect_result("tri_ccw", 0, 4);
    px[1] = 0; py[1] = 3;
    px[2] = 3; py[2] = 0;
    burst(0, 3, 3);
    expect_result("tri_cw", 0, 4);

    // Line y=0 against three circles.
    px[0] = 0; py[0] = 0; px[1] = 4; py[1] = 0;
    px[2] = 0; py[2] = 2; px[3] = 0; py[3] = 0;
    burst(1, 0, 4);
    expect_result("lc_tangent", 0, 2);
    px[2] = 0; py[2] = 1; px[3] = 0; py[3] = 3;
    burst(1, 0, 4);
    expect_result("lc_cross", 0, 1);
    px[2] = 0; py[2] = 5; px[3] = 0; py[3] = 6;
    burst(1, 0, 4);
    expect_result("lc_miss", 0, 0);

    // Bounding box with extreme coordinates and backpressure.
    px[0] = -128; py[0] = 5;
    px[1] = 127;  py[1] = -3;
    px[2] = 0;    py[2] = 0;
    px[3] = 10;   py[3] = -128;
    px[4] = -1;   py[4] = 127;
    burst(2, 5, 5);
    wait_valid("bb1");
    for (int i = 0; i < 3; i++) begin
      chk("bb1_hold_valid", int'(io.out_valid), 1);
      chk("bb1_min_x", int'(io.out_x), -128);
      chk("bb1_min_y", int'(io.out_y), -128);
      step();
    end
    io.out_ready = 1'b1;
    step();
    chk("bb2_valid", int'(io.out_valid), 1);
    chk("bb2_max_x", int'(io.out_x), 127);
    chk("bb2_max_y", int'(io.out_y), 127);
    step();
    io.out_ready = 1'b0;
    chk("bb_done", int'(io.out_valid), 0);

    // Error paths, each followed by a good burst.
    load_square();
    burst(0, 2, 2);
    expect_err("e_nv2");
    load_tri();
    burst(0, 3, 3);
    expect_result("e_nv2_recover", 0, 4);

    px[0] = 0; py[0] = 0; px[1] = 4; py[1] = 0;
    burst(1, 0, 2);
    expect_err("e_short");
    px[2] = 0; py[2] = 1; px[3] = 0; py[3] = 3;
    burst(1, 0, 4);
    expect_result("e_short_recover", 0, 1);

    load_square();
    burst(3, 4, 4);
    expect_err("e_mode3");
    burst(0, 4, 4);
    expect_result("e_mode3_recover", 0, 16);

    // Asynchronous reset while the result is waiting.
    load_square();
    burst(0, 4, 4);
    wait_valid("rst_mid");
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", int'(io.out_valid), 0);
    chk("rst_mid_x", int'(io.out_x), 0);
    chk("rst_mid_y", int'(io.out_y), 0);
    chk("rst_mid_err", int'(io.err), 0);
    #3;
    rst_n = 1'b1;
    step();
    chk("rst_mid_ready", int'(io.in_ready), 1);
    burst(0, 4, 4);
    expect_result("rst_mid_recover", 0, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
